pll_clkdiv_model: RTL
=====================

# pll_clkdiv_model

Behavioural stand-in for a vendor PLL, used in simulation and in small FPGA builds where no PLL primitive is available. It generates CH independent divided clocks, each with a matching one-cycle clock-enable pulse, derived from a single input clock. It also models PLL lock latency: outputs stay quiet until `lock` rises. Downstream logic uses either the `clkout` square waves or, preferably, the `ce` pulses in the `clk` domain.

## Interface
- `CH`, default 2: number of output channels (≥1).
- `DIV_W`, default 8: width of each channel's ratio field.
- `LOCK_CYCLES`, default 16: clock edges from reset release to `lock` (≥1).

- `clk`  in  1  input clock; sole clock of the block.
- `reset`  in  1  asynchronous, active-high reset.
- `div_ratio`  in  CH*DIV_W  per-channel ratio R; channel i uses bits [i*DIV_W +: DIV_W]. Enable period is R+1 cycles; clock period is 2*(R+1) cycles.
- `relock`  in  1  synchronous request to drop lock and re-run the lock sequence (see Configuration).
- `clkout`  out  CH  divided clocks; registered, 50% duty.
- `ce`  out  CH  one-`clk`-cycle enable pulse, coincident with each `clkout` toggle.
- `lock`  out  1  high once outputs are running.

## Operation
- Reset values:
  - `clkout`=0, `ce`=0, `lock`=0.
  - Lock counter = 0.
  - Channel counters = 0.
  - Active ratios = 0.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED: the lock counter increments each edge. When the counter equals LOCK_CYCLES-1, `lock`<=1 and the FSM enters LOCKED.
  - LOCKED: the counter holds.
  - Lock counter width: $clog2(LOCK_CYCLES+1).
- Channel i while `lock`=0:
  - cnt<=0, `ce[i]`<=0, `clkout[i]`<=0.
  - ratio_act<=R_i, reloaded every cycle.
- Channel i while `lock`=1:
  - If cnt==ratio_act: cnt<=0, `ce[i]`<=1, `clkout[i]`<=~`clkout[i]`, and ratio_act<=current R_i.
  - Else: cnt<=cnt+1, `ce[i]`<=0.
- Ratio changes take effect only at the terminal count, so no runt pulse or short clock phase is ever produced. A ratio change during a count finishes the old period first.
- R=0 gives `ce` continuously high and `clkout`=`clk`/2, the legacy dummy-PLL behaviour.
- R=2^DIV_W-1 is legal. The counter is DIV_W bits wide and never wraps past ratio_act.
- All channels restart with aligned phase whenever `lock` rises.

## Timing
- `lock` rises on edge LOCK_CYCLES after `reset` deasserts, where the first edge counts as 1.
- The first `ce[i]` occurs R_i+1 edges after the edge that raised `lock`. `clkout[i]` goes high on that same edge.
- After the first pulse, `ce[i]` repeats every R_i+1 edges. `clkout[i]` toggles on the same edges.
- `ce` and `clkout` change on the same edge; there is no relative latency.
- `relock` sampled high while LOCKED:
  - Next edge: `lock`<=0 and lock counter<=0.
  - The edge after that: channels clear (`ce`=0, `clkout`=0).
  - `lock` returns LOCK_CYCLES edges after `relock` is deasserted.
- `relock` held high keeps the lock counter at 0, so `lock` stays low for the whole time it is asserted.
- `reset` mid-operation: all outputs clear immediately (asynchronous) and the full lock sequence restarts. `reset` has priority over `relock`.

## Configuration
- `PLL_CLKDIV_RELOCK_EN` defined: `relock` is functional as described above.
- Macro undefined: the `relock` port is still present but ignored. `lock` falls only on `reset`, and the lock FSM has no LOCKED→UNLOCKED transition.

## Test plan
- Reset release with CH=2, LOCK_CYCLES=16, R={0,3}:
  - `lock` rises on edge 16.
  - `clkout[0]` toggles every edge after lock.
  - `ce[1]` pulses every 4 edges and `clkout[1]` has period 8.
- Before lock: `clkout`=0 and `ce`=0 on every cycle, regardless of `div_ratio`.
- Ratio change: with R_1=3, drive R_1=1 two edges after a `ce[1]`.
  - The next `ce[1]` still follows at the 4-edge spacing.
  - Subsequent pulses arrive every 2 edges, with no short `clkout` phase.
- Max ratio R=255 (DIV_W=8): `ce` exactly every 256 edges, `clkout` period 512. Check for no counter wrap over 3 periods.
- Relock (macro defined): pulse `relock` for 1 cycle while locked.
  - `lock`=0 on the next edge.
  - Outputs cleared one edge later.
  - `lock` returns 16 edges after `relock` deasserts, with both channels phase-aligned.
  - Macro undefined: the same stimulus leaves `lock` and outputs undisturbed.
- Async reset mid-run:
  - Assert `reset` between edges: outputs clear before the next edge.
  - Release: the full 16-edge lock sequence repeats.

Source files
------------

// File: rtl/pll_clkdiv_model.sv
// Behavioural PLL stand-in: CH divided clocks plus matching clock-enable pulses, held quiet until lock.
// Define PLL_CLKDIV_RELOCK_EN to make the relock input functional; otherwise it is ignored.
module pll_clkdiv_model #(
  parameter int unsigned CH          = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH*DIV_W-1:0]   div_ratio,
  input  logic                  relock,
  output logic [CH-1:0]         clkout,
  output logic [CH-1:0]         ce,
  output logic                  lock
);

  localparam int unsigned     CW        = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0]   LOCK_LAST = CW'(LOCK_CYCLES - 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t       r_state;
  lock_state_t       w_state_nxt;
  logic [CW-1:0]     r_lock_cnt;
  logic [CW-1:0]     w_lock_cnt_nxt;

  logic [DIV_W-1:0]  r_cnt   [CH];
  logic [DIV_W-1:0]  r_ratio [CH];
  logic [CH-1:0]     r_ce;
  logic [CH-1:0]     r_clkout;

`ifndef PLL_CLKDIV_RELOCK_EN
  logic w_unused_relock;
  assign w_unused_relock = relock;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= UNLOCKED;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    unique case (r_state)
      UNLOCKED: begin
`ifdef PLL_CLKDIV_RELOCK_EN
        // A held relock pins the counter at zero so lock cannot rise meanwhile.
        if (relock) begin
          w_lock_cnt_nxt = '0;
        end else
`endif
        begin
          w_lock_cnt_nxt = r_lock_cnt + CW'(1);
          if (r_lock_cnt == LOCK_LAST) begin
            w_state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
`ifdef PLL_CLKDIV_RELOCK_EN
        if (relock) begin
          w_state_nxt    = UNLOCKED;
          w_lock_cnt_nxt = '0;
        end
`endif
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  always_comb begin
    lock = (r_state == LOCKED);
  end

  // The active ratio is only reloaded at terminal count, so a period in flight always completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_cnt[i]   <= '0;
        r_ratio[i] <= '0;
      end
      r_ce     <= '0;
      r_clkout <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (!lock) begin
          r_cnt[i]    <= '0;
          r_ratio[i]  <= div_ratio[i*DIV_W +: DIV_W];
          r_ce[i]     <= 1'b0;
          r_clkout[i] <= 1'b0;
        end else if (r_cnt[i] == r_ratio[i]) begin
          r_cnt[i]    <= '0;
          r_ratio[i]  <= div_ratio[i*DIV_W +: DIV_W];
          r_ce[i]     <= 1'b1;
          r_clkout[i] <= ~r_clkout[i];
        end else begin
          r_cnt[i]    <= r_cnt[i] + 1'b1;
          r_ce[i]     <= 1'b0;
        end
      end
    end
  end

  assign ce     = r_ce;
  assign clkout = r_clkout;

endmodule
